spi_master_gen: RTL and testbench

//  Parametrised SPI master for the Wishbone peripheral set: configurable word width, multiple

---
 rtl/spi_master_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_master_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// SPI master with TX/RX word FIFOs, chip-select framing, gapless bursts and an RX overflow flag.
// Bus ack/err one cycle after a request; wr refused while TX full, received words dropped when RX full.

// Word FIFO; pop and push in the same cycle both take effect, even when full.
// Read data is the combinational head; full/empty come straight from the pointers.
module spi_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_pop, do_push;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// SPI master: bus requests answered next cycle; pins registered, SCK half-period = div+1 clocks.
// TX words queue until the FSM frames them; RX words pushed at end of word, dropped (rx_ovf) when full.
module spi_master_gen #(
    parameter int  DW    = 8,
    parameter int  NSS   = 4,
    parameter int  DIVW  = 8,
    parameter int  DEPTH = 16,
    localparam int SW    = (NSS > 1) ? $clog2(NSS) : 1,
    localparam int CW    = 3 + DIVW + SW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_wr,
    input  logic [CW-1:0]  cfg_din,
    input  logic           wr,
    input  logic [DW+2:0]  wr_din,
    input  logic           rd,
    output logic [DW-1:0]  rd_data,
    output logic           ack,
    output logic           err,
    output logic           busy,
    output logic           tx_full,
    output logic           rx_empty,
    output logic           rx_ovf,
    output logic           spi_sck,
    output logic           spi_mosi,
    output logic [NSS-1:0] spi_ss_n,
    input  logic           spi_miso
);
    localparam int BW = $clog2(DW);
    localparam logic [BW-1:0] LAST = BW'(DW - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, TRAIL} state_t;

    state_t          state;
    logic            cpha, cpol, lsb;
    logic [DIVW-1:0] div, cnt;
    logic [SW-1:0]   cs_sel;
    logic [DW-1:0]   tx_sh, rx_sh, rx_in, rx_head;
    logic [BW-1:0]   bc;
    logic            ph, cur_stop, cur_rx_en;
    logic [NSS-1:0]  sel_n;

    logic [DW+2:0]   tx_head;
    logic            tx_empty, tx_push, tx_pop, rx_full, rx_push, rx_pop;
    logic            cfg_ok, tick, idle_ready, idle_pop, eow, next_pop, sample, load;

    function automatic logic head_bit(input logic [DW-1:0] d, input logic lsb_f);
        return lsb_f ? d[0] : d[DW-1];
    endfunction

    function automatic logic [DW-1:0] advance(input logic [DW-1:0] d, input logic lsb_f);
        return lsb_f ? (d >> 1) : (d << 1);
    endfunction

    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NSS; i++) begin
            if (cs_sel == SW'(i)) sel_n[i] = 1'b0;
        end
    end

    assign busy       = state != IDLE;
    assign tick       = cnt == div;
    assign idle_ready = cnt >= div;
    assign cfg_ok     = cfg_wr && !busy;
    assign tx_push    = wr && !cfg_wr && !tx_full;
    assign rx_pop     = rd && !cfg_wr && !wr && !rx_empty;

    // IDLE only starts a frame once ss_n has been high for a full half-period.
    assign idle_pop = (state == IDLE) && !tx_empty && !cfg_wr && (!tx_head[DW] || idle_ready);
    assign eow      = (state == SHIFT) && tick && ph && (bc == LAST);
    assign next_pop = !tx_empty && ((eow && !cur_stop) || (state == GAP));
    assign tx_pop   = idle_pop || next_pop;
    assign load     = (idle_pop && tx_head[DW]) || next_pop;

    assign sample  = (state == SHIFT) && tick && (ph == cpha);
    assign rx_in   = lsb ? {spi_miso, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], spi_miso};
    assign rx_push = eow && cur_rx_en;

    spi_fifo #(.W(DW + 3), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(tx_push), .din(wr_din), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty)
    );

    spi_fifo #(.W(DW), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .din(sample ? rx_in : rx_sh), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cpha   <= 1'b0;
            cpol   <= 1'b0;
            lsb    <= 1'b0;
            div    <= '0;
            cs_sel <= '0;
        end else if (cfg_ok) begin
            cpha   <= cfg_din[0];
            cpol   <= cfg_din[1];
            lsb    <= cfg_din[2];
            div    <= cfg_din[DIVW+2:3];
            cs_sel <= cfg_din[CW-1:DIVW+3];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            rd_data <= '0;
            rx_ovf  <= 1'b0;
        end else begin
            ack <= cfg_ok || tx_push || rx_pop;
            err <= (cfg_wr && busy) || (!cfg_wr && wr && tx_full) ||
                   (!cfg_wr && !wr && rd && rx_empty);
            if (rx_pop) rd_data <= rx_head;
            if (cfg_ok) rx_ovf <= 1'b0;
            else if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            spi_ss_n  <= '1;
            tx_sh     <= '0;
            rx_sh     <= '0;
            bc        <= '0;
            ph        <= 1'b0;
            cur_stop  <= 1'b0;
            cur_rx_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    spi_sck  <= cpol;
                    spi_ss_n <= '1;
                    if (!idle_ready) cnt <= cnt + 1'b1;
                    if (idle_pop && tx_head[DW]) begin
                        spi_ss_n <= sel_n;
                        state    <= LEAD;
                        cnt      <= '0;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!tick) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt     <= '0;
                        spi_sck <= ~spi_sck;
                        ph      <= ~ph;
                        if (sample) rx_sh <= rx_in;
                        // CPHA=0 drives on trailing edges except after the last bit.
                        if ((cpha && !ph) || (!cpha && ph && bc != LAST)) begin
                            spi_mosi <= head_bit(tx_sh, lsb);
                            tx_sh    <= advance(tx_sh, lsb);
                        end
                        if (ph) bc <= bc + 1'b1;
                        if (eow && cur_stop)       state <= TRAIL;
                        else if (eow && tx_empty)  state <= GAP;
                    end
                end
                GAP: begin
                    cnt <= '0;
                    if (next_pop) state <= SHIFT;
                end
                TRAIL: begin
                    if (tick) begin
                        state    <= IDLE;
                        spi_ss_n <= '1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                cur_stop  <= tx_head[DW+1];
                cur_rx_en <= tx_head[DW+2];
                bc        <= '0;
                ph        <= 1'b0;
                if (cpha) begin
                    tx_sh <= tx_head[DW-1:0];
                end else begin
                    tx_sh    <= advance(tx_head[DW-1:0], lsb);
                    spi_mosi <= head_bit(tx_head[DW-1:0], lsb);
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: pin-level monitor decodes SPI frames, MISO loops back MOSI.
`timescale 1ns/1ps
module tb_spi_master_gen;
    localparam int DW = 8, NSS = 4, DIVW = 8, DEPTH = 16, SW = 2, CW = 13;

    logic clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [CW-1:0]  cfg_din = '0;
    logic [DW+2:0]  wr_din = '0;
    logic [DW-1:0]  rd_data;
    logic           ack, err, busy, tx_full, rx_empty, rx_ovf, spi_sck, spi_mosi, spi_miso;
    logic [NSS-1:0] spi_ss_n;

    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign spi_miso = spi_mosi;

    spi_master_gen #(.DW(DW), .NSS(NSS), .DIVW(DIVW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_din(cfg_din), .wr(wr), .wr_din(wr_din),
        .rd(rd), .rd_data(rd_data), .ack(ack), .err(err), .busy(busy), .tx_full(tx_full),
        .rx_empty(rx_empty), .rx_ovf(rx_ovf), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_ss_n(spi_ss_n), .spi_miso(spi_miso)
    );

    // Pin monitor: a frame is any stretch with some ss_n low.
    logic m_cpol = 1'b0, m_cpha = 1'b0, prev_sck = 1'b0, in_frame = 1'b0, ss_bad = 1'b0, f_bad = 1'b0;
    logic [NSS-1:0] cur_ss = '1, f_ss = '1;
    logic mq[$];
    logic f_bits[$];
    int cyc = 0, frames = 0, lead_cnt = 0, last_edge = -1, first_int = 0, max_int = 0, edge_total = 0;
    int f_lead = 0, f_half = 0, f_max = 0;

    always @(negedge clk) begin
        cyc++;
        if (spi_ss_n != '1) begin
            if (!in_frame) begin
                in_frame = 1'b1; cur_ss = spi_ss_n; lead_cnt = 0; mq.delete();
                last_edge = -1; first_int = 0; max_int = 0; ss_bad = 1'b0;
            end else if (spi_ss_n != cur_ss) begin
                ss_bad = 1'b1;
            end
            if (spi_sck != prev_sck) begin
                edge_total++;
                if (prev_sck == m_cpol) lead_cnt++;
                if ((prev_sck == m_cpol) == (m_cpha == 1'b0)) mq.push_back(spi_mosi);
                if (last_edge >= 0) begin
                    if (first_int == 0) first_int = cyc - last_edge;
                    if (cyc - last_edge > max_int) max_int = cyc - last_edge;
                end
                last_edge = cyc;
            end
        end else if (in_frame) begin
            in_frame = 1'b0; f_bits = mq; f_lead = lead_cnt; f_ss = cur_ss;
            f_half = first_int; f_max = max_int; f_bad = ss_bad; frames++;
        end
        prev_sck = spi_sck;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Expected serial order of a word, first transmitted bit in the MSB.
    function automatic logic [DW-1:0] stream_of(input logic [DW-1:0] d, input logic lf);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < DW; i++) s = {s[DW-2:0], lf ? d[i] : d[DW-1-i]};
        return s;
    endfunction

    function automatic logic [DW-1:0] bits_word(input int idx);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < DW; i++)
            w = {w[DW-2:0], (idx * DW + i < f_bits.size()) ? f_bits[idx * DW + i] : 1'bx};
        return w;
    endfunction

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int kind, input logic [CW-1:0] c, input logic [DW+2:0] w,
                         output logic a, output logic e);
        cfg_wr = (kind == 0); wr = (kind == 1); rd = (kind == 2); cfg_din = c; wr_din = w;
        @(posedge clk); #1;
        cfg_wr = 1'b0; wr = 1'b0; rd = 1'b0;
        a = ack; e = err;
    endtask

    task automatic do_cfg(input logic cp, input logic ch, input logic lf,
                          input logic [DIVW-1:0] dv, input logic [SW-1:0] cs);
        logic a, e;
        pulse(0, {cs, dv, lf, cp, ch}, '0, a, e);
        check("cfg_ack", a, 1'b1);
        m_cpol = cp; m_cpha = ch;
    endtask

    task automatic wr_word(input logic [DW-1:0] d, input logic st, input logic sp, input logic rx);
        logic a, e;
        pulse(1, '0, {rx, sp, st, d}, a, e);
        check("wr_ack", a, 1'b1);
    endtask

    task automatic rd_word(input logic [DW-1:0] exp);
        logic a, e;
        pulse(2, '0, '0, a, e);
        check("rd_ack", a, 1'b1);
        check("rd_data", rd_data, exp);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("frame_done", frames >= target, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("idle_reached", busy, 1'b0);
    endtask

    typedef struct {
        logic cpol, cpha, lsb;
        logic [DIVW-1:0] div;
        logic [SW-1:0] cs;
        logic [DW-1:0] data, stream;
        logic [NSS-1:0] ss;
        int half;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [DW-1:0] wd[3];
        logic [DW-1:0] ovq[$];
        logic a, e;
        logic [NSS-1:0] ss_snap;
        int f0, e0, nw, guard;

        tbl[0] = '{cpol:0, cpha:0, lsb:0, div:1, cs:2, data:8'hA5, stream:8'hA5, ss:4'b1011, half:2};
        tbl[1] = '{cpol:1, cpha:1, lsb:1, div:0, cs:0, data:8'h35, stream:8'hAC, ss:4'b1110, half:1};
        tbl[2] = '{cpol:0, cpha:1, lsb:0, div:2, cs:3, data:8'h3C, stream:8'h3C, ss:4'b0111, half:3};
        tbl[3] = '{cpol:1, cpha:0, lsb:1, div:3, cs:1, data:8'h01, stream:8'h80, ss:4'b1101, half:4};

        tick_n(3);
        check("rst_ss_n", spi_ss_n, 4'hF);
        check("rst_sck", spi_sck, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_ack_err", {ack, err}, 2'b00);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_flags", {busy, rx_ovf, rx_empty, tx_full}, 4'b0010);
        rst = 1'b0;
        tick_n(1);

        for (int k = 0; k < 4; k++) begin
            do_cfg(tbl[k].cpol, tbl[k].cpha, tbl[k].lsb, tbl[k].div, tbl[k].cs);
            tick_n(3);
            check("tbl_idle_sck", spi_sck, tbl[k].cpol);
            f0 = frames;
            wr_word(tbl[k].data, 1'b1, 1'b1, 1'b1);
            wait_frames(f0 + 1, 400);
            check("tbl_stream", bits_word(0), tbl[k].stream);
            check("tbl_nbits", f_bits.size(), DW);
            check("tbl_ss", f_ss, tbl[k].ss);
            check("tbl_lead", f_lead, DW);
            check("tbl_half", f_half, tbl[k].half);
            wait_idle(50);
            rd_word(tbl[k].data);
        end

        // Mode 3, LSB first, three-word gapless burst in one frame.
        do_cfg(1'b1, 1'b1, 1'b1, 8'd1, 2'd1);
        for (int i = 0; i < 3; i++) wd[i] = DW'($urandom);
        f0 = frames;
        wr_word(wd[0], 1'b1, 1'b0, 1'b1);
        wr_word(wd[1], 1'b0, 1'b0, 1'b1);
        wr_word(wd[2], 1'b0, 1'b1, 1'b1);
        wait_frames(f0 + 1, 400);
        wait_idle(50);
        check("burst_frames", frames, f0 + 1);
        check("burst_lead", f_lead, 3 * DW);
        check("burst_gapless", f_max, 2);
        check("burst_ss_stable", f_bad, 1'b0);
        for (int i = 0; i < 3; i++) check("burst_stream", bits_word(i), stream_of(wd[i], 1'b1));
        for (int i = 0; i < 3; i++) rd_word(wd[i]);

        // Mode 1, first word without stop and TX empty: frame parks in GAP.
        do_cfg(1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        wd[0] = DW'($urandom); wd[1] = DW'($urandom);
        f0 = frames;
        wr_word(wd[0], 1'b1, 1'b0, 1'b1);
        tick_n(40);
        e0 = edge_total;
        tick_n(100);
        check("gap_no_edges", edge_total, e0);
        check("gap_ss_n", spi_ss_n, 4'b1110);
        check("gap_sck", spi_sck, 1'b0);
        check("gap_busy", busy, 1'b1);
        wr_word(wd[1], 1'b0, 1'b1, 1'b1);
        wait_frames(f0 + 1, 200);
        check("gap_lead", f_lead, 2 * DW);
        check("gap_w0", bits_word(0), stream_of(wd[0], 1'b0));
        check("gap_w1", bits_word(1), stream_of(wd[1], 1'b0));
        wait_idle(50);
        rd_word(wd[0]);
        rd_word(wd[1]);

        // Randomised transfers against the frame-level model.
        for (int t = 0; t < 12; t++) begin
            logic cp, ch, lf;
            logic [DIVW-1:0] dv;
            logic [SW-1:0] cs;
            logic [NSS-1:0] exp_ss;
            cp = 1'($urandom); ch = 1'($urandom); lf = 1'($urandom);
            dv = DIVW'($urandom_range(0, 3)); cs = SW'($urandom_range(0, 3));
            nw = $urandom_range(1, 3);
            exp_ss = '1; exp_ss[cs] = 1'b0;
            do_cfg(cp, ch, lf, dv, cs);
            f0 = frames;
            for (int i = 0; i < nw; i++) begin
                wd[i] = DW'($urandom);
                wr_word(wd[i], i == 0, i == nw - 1, 1'b1);
            end
            wait_frames(f0 + 1, 600);
            check("rnd_ss", f_ss, exp_ss);
            check("rnd_lead", f_lead, nw * DW);
            check("rnd_half", f_half, int'(dv) + 1);
            for (int i = 0; i < nw; i++) check("rnd_stream", bits_word(i), stream_of(wd[i], lf));
            wait_idle(50);
            for (int i = 0; i < nw; i++) rd_word(wd[i]);
        end

        // RX overflow: DEPTH+1 received words with no reads.
        do_cfg(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        f0 = frames;
        for (int i = 0; i <= DEPTH; i++) begin
            guard = 0;
            while (tx_full && guard < 100) begin
                tick_n(1); guard++;
            end
            ovq.push_back(DW'($urandom));
            wr_word(ovq[i], 1'b1, 1'b1, 1'b1);
        end
        wait_frames(f0 + DEPTH + 1, 40 * (DEPTH + 1));
        wait_idle(50);
        check("ovf_set", rx_ovf, 1'b1);
        for (int i = 0; i < DEPTH; i++) rd_word(ovq[i]);
        check("ovf_rx_empty", rx_empty, 1'b1);
        pulse(2, '0, '0, a, e);
        check("rd_empty_err", {a, e}, 2'b01);
        check("rd_empty_hold", rd_data, ovq[DEPTH-1]);
        check("ovf_sticky", rx_ovf, 1'b1);
        do_cfg(1'b0, 1'b0, 1'b0, 8'd255, 2'd0);
        check("ovf_cleared", rx_ovf, 1'b0);

        // Slow transfer to fill TX, then rejected requests and reset mid-SHIFT.
        wr_word(8'h11, 1'b1, 1'b1, 1'b0);
        guard = 0;
        while (!busy && guard < 400) begin
            tick_n(1); guard++;
        end
        check("slow_busy", busy, 1'b1);
        for (int i = 0; i < DEPTH; i++) wr_word(DW'(i), 1'b1, 1'b1, 1'b0);
        check("tx_full", tx_full, 1'b1);
        pulse(1, '0, {3'b111, 8'h77}, a, e);
        check("wr_full_err", {a, e}, 2'b01);
        ss_snap = spi_ss_n;
        pulse(0, {2'd3, 8'd0, 3'b011}, '0, a, e);
        check("cfg_busy_err", {a, e}, 2'b01);
        check("cfg_busy_ss", spi_ss_n, ss_snap);
        tick_n(600);
        check("mid_shift_ss", spi_ss_n, 4'b1110);
        rst = 1'b1;
        tick_n(1);
        check("rst_mid_ss_n", spi_ss_n, 4'hF);
        check("rst_mid_sck", spi_sck, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rx_empty", rx_empty, 1'b1);
        check("rst_mid_tx_full", tx_full, 1'b0);
        rst = 1'b0;
        tick_n(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
